addsub_serial: RTL and testbench

- Parametrised, multi-cycle add/subtract unit.
- Processes a WIDTH-bit operation CHUNK bits per clock, rippling the carry between chunks through a register.
- Adds a start/busy/done handshake and result flags (carry, signed overflow, zero, negative).
- Serves as the shared arithmetic engine for the lab datapath wherever area matters more than latency.

---
 rtl/addsub_serial.sv | 150 +++++++++++++++
 tb/tb_addsub_serial.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/addsub_serial.sv
// Multi-cycle add/subtract: WIDTH bits in WIDTH/CHUNK clocks, carry rippled through a register.
// Optional macro ADDSUB_SATURATE_EN clamps an overflowing result when sat was set at start.
module addsub_serial #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             m,
    input  logic             sat,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             v,
    output logic             z,
    output logic             n
);
    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  s_q, s_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic              done_q, done_d;
    logic              cout_q, cout_d;
    logic              v_q, v_d;
    logic              z_q, z_d;
    logic              n_q, n_d;
    logic              sat_q, sat_d;

    logic [CHUNK-1:0]  a_chunk, b_chunk;
    logic [CHUNK:0]    csum;
    logic [WIDTH-1:0]  s_shift, s_fin;
    logic              c_msb_in, v_w;

    // Operands shift right one chunk per cycle; sum chunks enter s from the top.
    always_comb begin
        a_chunk  = a_q[CHUNK-1:0];
        b_chunk  = b_q[CHUNK-1:0];
        csum     = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
        s_shift  = (s_q >> CHUNK) | (WIDTH'(csum[CHUNK-1:0]) << (WIDTH - CHUNK));
        c_msb_in = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ csum[CHUNK-1];
        v_w      = c_msb_in ^ csum[CHUNK];
    end

`ifdef ADDSUB_SATURATE_EN
    // On the last chunk a_chunk's MSB is the original sign of a.
    always_comb begin
        s_fin = s_shift;
        if (sat_q && v_w)
            s_fin = a_chunk[CHUNK-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`else
    logic unused_sat;
    assign unused_sat = sat;
    assign s_fin      = s_shift;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        done_d  = 1'b0;
        cout_d  = cout_q;
        v_d     = v_q;
        z_d     = z_q;
        n_d     = n_q;
        sat_d   = sat_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = m ? ~b : b;
                    carry_d = m ? 1'b1 : cin;
                    sat_d   = sat;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                s_d     = s_shift;
                carry_d = csum[CHUNK];
                idx_d   = idx_q + IDXW'(1);
                if (idx_q == IDXW'(N - 1)) begin
                    s_d     = s_fin;
                    cout_d  = csum[CHUNK];
                    v_d     = v_w;
                    z_d     = (s_fin == '0);
                    n_d     = s_fin[WIDTH-1];
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            done_q  <= done_d;
            cout_q  <= cout_d;
            v_q     <= v_d;
            z_q     <= z_d;
            n_q     <= n_d;
            sat_q   <= sat_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign s    = s_q;
    assign cout = cout_q;
    assign v    = v_q;
    assign z    = z_q;
    assign n    = n_q;
endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial (WIDTH=16, CHUNK=4): directed table, handshake sequences, random vs. model.
module tb_addsub_serial;
    localparam int W = 16;
    localparam int LAT = 4;
`ifdef ADDSUB_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         cin = 1'b0, m = 1'b0, sat = 1'b0;
    logic         busy, done, cout, v, z, n;
    logic [W-1:0] s;

    int vectors = 0;
    int miscompares = 0;

    addsub_serial #(.WIDTH(W), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .m(m), .sat(sat),
        .busy(busy), .done(done), .s(s), .cout(cout), .v(v), .z(z), .n(n)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a, b;
        logic         cin, m, sat;
        logic [W-1:0] s;
        logic         cout, v, z, n;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic and two's-complement sign rules.
    task automatic model(input logic [W-1:0] ma, mb, input logic mcin, mm, msat,
                         output logic [W-1:0] ms, output logic mcout, mv);
        logic [W:0] full;
        if (mm) full = {1'b0, ma} + {1'b0, ~mb} + 17'd1;
        else    full = {1'b0, ma} + {1'b0, mb} + {16'd0, mcin};
        ms    = full[W-1:0];
        mcout = full[W];
        if (mm) mv = (ma[W-1] != mb[W-1]) && (ms[W-1] != ma[W-1]);
        else    mv = (ma[W-1] == mb[W-1]) && (ms[W-1] != ma[W-1]);
        if (SAT && msat && mv) ms = ma[W-1] ? 16'h8000 : 16'h7FFF;
    endtask

    task automatic do_start(input logic [W-1:0] ta, tb, input logic tcin, tm, tsat);
        @(negedge clk);
        a = ta; b = tb; cin = tcin; m = tm; sat = tsat; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        while (!done && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] ta, tb, input logic tcin, tm, tsat,
                          input logic [W-1:0] es, input logic ecout, ev, ez, en);
        int lat;
        do_start(ta, tb, tcin, tm, tsat);
        wait_done(lat);
        check({tag, ".latency"}, lat, LAT);
        check({tag, ".s"}, s, es);
        check({tag, ".cout"}, cout, ecout);
        check({tag, ".v"}, v, ev);
        check({tag, ".z"}, z, ez);
        check({tag, ".n"}, n, en);
        @(negedge clk);
        check({tag, ".done_pulse"}, done, 0);
        check({tag, ".hold_s"}, s, es);
    endtask

    initial begin
        int lat;
        bit seen;
        logic [W-1:0] es;
        logic ec, ev;

        tbl[0] = '{16'h1234, 16'h0F0F, 1'b1, 1'b0, 1'b0, 16'h2144, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, SAT ? 16'h7FFF : 16'h8000,
                   1'b0, 1'b1, 1'b0, !SAT};
        tbl[6] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1, SAT ? 16'h8000 : 16'h7FFF,
                   1'b1, 1'b1, 1'b0, SAT};
        tbl[7] = '{16'h0100, 16'h0100, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};

        // Asynchronous reset mid-cycle, no clock edge in between.
        #2 rst = 1'b1;
        #1;
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.s", s, 0);
        check("rst.flags", {cout, v, z, n}, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rel.busy", busy, 0);
        check("rel.done", done, 0);

        foreach (tbl[i])
            run_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].m, tbl[i].sat,
                   tbl[i].s, tbl[i].cout, tbl[i].v, tbl[i].z, tbl[i].n);

        // Outputs nonzero from last op; a mid-cycle reset must clear them at once.
        run_op("pre", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rst2.s", s, 0);
        check("rst2.flags", {cout, v, z, n}, 0);
        @(negedge clk);
        rst = 1'b0;

        // start re-pulsed while busy with different operands must be ignored.
        do_start(16'h1234, 16'h0F0F, 1'b1, 1'b0, 1'b0);
        a = 16'hAAAA; b = 16'h5555; m = 1'b1; start = 1'b1;
        @(negedge clk); @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        check("ign.latency", lat + 2, LAT);
        check("ign.s", s, 16'h2144);

        // Back-to-back: start in the done cycle, second done five cycles later.
        do_start(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0);
        wait_done(lat);
        check("b2b.first", done, 1);
        a = 16'h0F00; b = 16'h00F0; cin = 1'b0; m = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b.done_drop", done, 0);
        check("b2b.busy", busy, 1);
        wait_done(lat);
        check("b2b.gap", lat + 1, 5);
        check("b2b.s", s, 16'h0FF0);

        // Abort: reset two cycles after start, no done afterwards.
        do_start(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort.busy", busy, 0);
        check("abort.s", s, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            seen |= done;
        end
        check("abort.no_done", seen, 0);

        for (int r = 0; r < 200; r++) begin
            logic [W-1:0] ra, rb;
            logic rc, rm, rs;
            ra = W'($urandom); rb = W'($urandom);
            if (r % 8 == 0) rb = ra;
            rc = 1'($urandom); rm = 1'($urandom); rs = 1'($urandom);
            model(ra, rb, rc, rm, rs, es, ec, ev);
            run_op($sformatf("rnd%0d", r), ra, rb, rc, rm, rs, es, ec, ev, es == 0, es[W-1]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
